// File: rtl/tdm_demux.sv
// tdm_demux: routes a time-multiplexed sample stream into NCH per-channel
// registers. A two-state framer (HUNT/LOCK) aligns to frame_sync, tracks the
// next channel index in sel, and flags framing violations on frame_err.
//
// Handshake: din_valid qualifies din/frame_sync for exactly the cycle it is
// high; there is no back-pressure, so every valid sample is consumed on the
// edge it is presented. ch_valid/frame_done/frame_err are single-cycle
// registered pulses describing the sample consumed on the previous edge.
// The framer state is visible on locked (1 = LOCK, 0 = HUNT).
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic [NCH-1:0]         ch_valid,
  output logic [SEL_W-1:0]       sel,
  output logic                   locked,
  output logic                   frame_done,
  output logic                   frame_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);
  localparam logic [SEL_W-1:0] CH0     = '0;
  localparam logic [SEL_W-1:0] CH1     = SEL_W'(1);

  state_t           state, nxt_state;
  logic [SEL_W-1:0] nxt_sel;
  logic             wr_en;
  logic [SEL_W-1:0] wr_ch;
  logic             err;

  // State register: framer state and the next-channel pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      sel   <= '0;
    end else begin
      state <= nxt_state;
      sel   <= nxt_sel;
    end
  end

  // Next-state logic: a sync always restarts the frame at channel 1; a
  // missing sync where channel 0 was expected drops back to HUNT.
  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            nxt_state = LOCK;
            nxt_sel   = CH1;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            nxt_sel = CH1;
          end else if (sel == CH0) begin
            nxt_state = HUNT;
          end else if (sel == LAST_CH) begin
            nxt_sel = CH0;
          end else begin
            nxt_sel = sel + CH1;
          end
        end
        default: nxt_state = HUNT;
      endcase
    end
  end

  // Output decode: which channel (if any) this sample writes, and whether
  // it violates framing (early sync or missing sync).
  always_comb begin
    wr_en = 1'b0;
    wr_ch = CH0;
    err   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          wr_en = frame_sync;
        end
        LOCK: begin
          if (frame_sync) begin
            wr_en = 1'b1;
            err   = (sel != CH0);
          end else if (sel == CH0) begin
            err   = 1'b1;
          end else begin
            wr_en = 1'b1;
            wr_ch = sel;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: channel data, one-hot update strobe and frame flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr_en && (wr_ch == SEL_W'(k))) begin
          dout[k*WIDTH +: WIDTH] <= din;
        end
      end
      ch_valid   <= wr_en ? (NCH'(1) << wr_ch) : '0;
      frame_done <= wr_en && (wr_ch == LAST_CH);
      frame_err  <= err;
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (NCH=4, WIDTH=8): directed scenarios plus a random
// back-to-back stream, all tracked by a reference model feeding a queue.
module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int EW    = NCH*WIDTH + NCH + 3 + SEL_W;

  logic                 clk;
  logic                 rst_n;
  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic [NCH*WIDTH-1:0] dout;
  logic [NCH-1:0]       ch_valid;
  logic [SEL_W-1:0]     sel;
  logic                 locked;
  logic                 frame_done;
  logic                 frame_err;

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .ch_valid(ch_valid), .sel(sel),
    .locked(locked), .frame_done(frame_done), .frame_err(frame_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {dout, ch_valid, frame_done, frame_err, locked, sel}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_r, act_r;

  // Reference model state
  bit                   m_lock;
  int                   m_sel;
  logic [NCH*WIDTH-1:0] m_dout;

  task automatic model_reset();
    m_lock = 1'b0;
    m_sel  = 0;
    m_dout = '0;
    exp_q.delete();
  endtask

  // Driver: presents one cycle of input and pushes the expected result.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic fs);
    logic [NCH-1:0] chv;
    logic fd, fe;
    int ch;
    @(negedge clk);
    din_valid = v; din = d; frame_sync = fs;
    chv = '0; fd = 1'b0; fe = 1'b0; ch = -1;
    if (v) begin
      if (!m_lock) begin
        if (fs) begin ch = 0; m_sel = 1; m_lock = 1'b1; end
      end else if (fs) begin
        fe = (m_sel != 0); ch = 0; m_sel = 1;
      end else if (m_sel == 0) begin
        fe = 1'b1; m_lock = 1'b0;
      end else begin
        ch = m_sel; m_sel = (m_sel + 1) % NCH;
      end
    end
    if (ch >= 0) begin
      m_dout[ch*WIDTH +: WIDTH] = d;
      chv[ch] = 1'b1;
      fd = (ch == NCH-1);
    end
    exp_q.push_back({m_dout, chv, fd, fe, m_lock, SEL_W'(m_sel)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  // Waits until the sample just driven has been registered.
  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compares every driven cycle one step after the edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {dout, ch_valid, frame_done, frame_err, locked, sel};
      checks++;
      if (act_r !== exp_r) begin
        errors++;
        $display("FAIL scoreboard t=%0t dout=%h exp %h ch_valid=%b exp %b fd=%b exp %b fe=%b exp %b locked=%b exp %b sel=%0d exp %0d",
                 $time, act_r[EW-1 -: 32], exp_r[EW-1 -: 32], act_r[8:5], exp_r[8:5],
                 act_r[4], exp_r[4], act_r[3], exp_r[3], act_r[2], exp_r[2], act_r[1:0], exp_r[1:0]);
      end
      checks++;
      if ($countones(ch_valid) > 1 || (frame_done && frame_err)) begin
        errors++;
        $display("FAIL pulse_exclusive t=%0t ch_valid=%b fd=%b fe=%b required onehot0 and not fd&fe",
                 $time, ch_valid, frame_done, frame_err);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (dout !== '0)      begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (ch_valid !== '0)  begin errors++; $display("FAIL reset_ch_valid got %b want 0", ch_valid); end
    checks++; if (sel !== '0)       begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fd=%b fe=%b want 0 0", frame_done, frame_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_lock_frame();
    logic [WIDTH-1:0] data [4];
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, data[i], i == 0);
      settle();
      checks++;
      if (ch_valid !== NCH'(1 << i) || frame_done !== (i == 3) || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL lock_step%0d got ch_valid=%b fd=%b fe=%b want %b %b 0",
                 i, ch_valid, frame_done, frame_err, NCH'(1 << i), (i == 3));
      end
    end
    checks++; if (dout !== 32'h44332211) begin errors++; $display("FAIL lock_dout got %h want 44332211", dout); end
    checks++; if (locked !== 1'b1)       begin errors++; $display("FAIL lock_locked got %b want 1", locked); end
  endtask

  task automatic test_hunt_drop();
    apply_reset();
    drive(1'b1, 8'hAA, 1'b0); settle();
    drive(1'b1, 8'hBB, 1'b0); settle();
    checks++;
    if (dout !== '0 || locked !== 1'b0 || frame_err !== 1'b0 || ch_valid !== '0) begin
      errors++; $display("FAIL hunt_drop got dout=%h locked=%b fe=%b chv=%b want 0 0 0 0", dout, locked, frame_err, ch_valid);
    end
    drive(1'b1, 8'h01, 1'b1); settle();
    checks++;
    if (dout !== 32'h00000001 || locked !== 1'b1 || ch_valid !== 4'b0001) begin
      errors++; $display("FAIL hunt_relock got dout=%h locked=%b chv=%b want 00000001 1 0001", dout, locked, ch_valid);
    end
  endtask

  task automatic test_early_sync();
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    drive(1'b1, 8'h10, 1'b1); settle();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_normal_start got fe=%b want 0", frame_err); end
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h30, 1'b1); settle();
    checks++;
    if (frame_err !== 1'b1 || dout !== 32'h04032030 || sel !== 2'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL early_sync got fe=%b dout=%h sel=%0d locked=%b want 1 04032030 1 1", frame_err, dout, sel, locked);
    end
  endtask

  task automatic test_missing_sync();
    drive(1'b1, 8'h40, 1'b0);
    drive(1'b1, 8'h50, 1'b0);
    drive(1'b1, 8'h60, 1'b0);
    drive(1'b1, 8'h55, 1'b0); settle();
    checks++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || dout !== 32'h60504030 || ch_valid !== '0 || sel !== 2'd0) begin
      errors++; $display("FAIL missing_sync got fe=%b locked=%b dout=%h chv=%b sel=%0d want 1 0 60504030 0 0",
                         frame_err, locked, dout, ch_valid, sel);
    end
    drive(1'b1, 8'h66, 1'b1); settle();
    checks++;
    if (locked !== 1'b1 || dout[7:0] !== 8'h66 || frame_err !== 1'b0) begin
      errors++; $display("FAIL missing_relock got locked=%b ch0=%h fe=%b want 1 66 0", locked, dout[7:0], frame_err);
    end
  endtask

  task automatic test_back_to_back();
    logic fs;
    for (int k = 0; k < 48; k++) begin
      fs = ((k % NCH) == 0) ^ ($urandom_range(0, 9) == 0);
      drive(1'b1, WIDTH'($urandom_range(0, 255)), fs);
    end
    settle();
    checks++;
    if (locked !== m_lock || dout !== m_dout) begin
      errors++; $display("FAIL b2b_final got locked=%b dout=%h want %b %h", locked, dout, m_lock, m_dout);
    end
  endtask

  task automatic test_gapped_and_reset();
    logic [WIDTH-1:0] data [4];
    data[0] = 8'hA1; data[1] = 8'hB2; data[2] = 8'hC3; data[3] = 8'hD4;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, data[i], i == 0);
      idle($urandom_range(1, 3));
    end
    settle();
    checks++;
    if (dout !== 32'hD4C3B2A1 || locked !== 1'b1) begin
      errors++; $display("FAIL gapped_frame got dout=%h locked=%b want D4C3B2A1 1", dout, locked);
    end
    drive(1'b1, 8'hE1, 1'b1);
    drive(1'b1, 8'hE2, 1'b0);
    settle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || locked !== 1'b0 || sel !== '0 || ch_valid !== '0) begin
      errors++; $display("FAIL async_reset got dout=%h locked=%b sel=%0d chv=%b want 0 0 0 0", dout, locked, sel, ch_valid);
    end
    din_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 8'hE3, 1'b0); settle();
    checks++;
    if (dout !== '0 || locked !== 1'b0) begin
      errors++; $display("FAIL post_reset_hunt got dout=%h locked=%b want 0 0", dout, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock_frame();
    test_hunt_drop();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_gapped_and_reset();
    idle(2);
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
